// File: rtl/sha1_msg_padder.sv
// Streaming SHA-1 message padder: turns big-endian 32-bit message beats into padded
// 512-bit blocks emitted as 16 sequential words with block/message end flags.
module sha1_msg_padder #(
   parameter int BYTE_CNT_W = 32
) (
   input  logic        wb_clk_i,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic [2:0]  in_bytes,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_block_end,
   output logic        out_msg_end,
   output logic        busy,
   output logic        err,
   output logic [2:0]  dbg_state_o
);

   // Handshake: a transfer happens on a rising edge where valid & ready are both high;
   // a producer holds data/flags stable while valid is high and ready is low.

   typedef enum logic [2:0] {
      S_DATA = 3'd0,
      S_MARK = 3'd1,
      S_ZERO = 3'd2,
      S_LENH = 3'd3,
      S_LENL = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic [3:0]              wcnt_q, wcnt_d;
   logic [BYTE_CNT_W-1:0]   cnt_q, cnt_d;
   logic                    err_q, err_d;
   logic                    ov_q, ov_d;
   logic [31:0]             od_q, od_d;
   logic                    be_q, be_d;
   logic                    me_q, me_d;

   logic                    load;
   logic                    accept;
   logic                    bad_bytes;
   logic [2:0]              k;
   logic [31:0]             keep;
   logic [31:0]             mark;
   logic [BYTE_CNT_W:0]     sum;
   logic [63:0]             len;
   state_t                  pad_next;
   logic                    emit;
   logic [31:0]             word;
   logic                    word_me;

   always_comb begin
      load      = !ov_q | out_ready;
      in_ready  = !reset & (state_q == S_DATA) & load;
      accept    = in_valid & in_ready;
      bad_bytes = (in_bytes > 3'd4) | ((in_bytes < 3'd4) & !in_last);
      k         = bad_bytes ? 3'd4 : in_bytes;
      sum       = {1'b0, cnt_q} + {{(BYTE_CNT_W-2){1'b0}}, k};
      len       = '0;
      len[BYTE_CNT_W+2:3] = cnt_q;
      // A word loaded at index 13 hands over to the length so words 14/15 carry it.
      pad_next  = (wcnt_q == 4'd13) ? S_LENH : S_ZERO;
      keep      = 32'hFFFF_FFFF;
      mark      = 32'h0000_0000;
      case (k)
         3'd1:    begin keep = 32'hFF00_0000; mark = 32'h0080_0000; end
         3'd2:    begin keep = 32'hFFFF_0000; mark = 32'h0000_8000; end
         3'd3:    begin keep = 32'hFFFF_FF00; mark = 32'h0000_0080; end
         default: begin keep = 32'hFFFF_FFFF; mark = 32'h0000_0000; end
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      emit    = 1'b0;
      word    = 32'h0;
      word_me = 1'b0;
      case (state_q)
         S_DATA: begin
            if (accept) begin
               emit  = 1'b1;
               cnt_d = sum[BYTE_CNT_W-1:0];
               if (sum[BYTE_CNT_W] | bad_bytes) err_d = 1'b1;
               if (!in_last) begin
                  word = in_data;
               end else if (k == 3'd4) begin
                  word    = in_data;
                  state_d = S_MARK;
               end else if (k == 3'd0) begin
                  word    = 32'h8000_0000;
                  state_d = pad_next;
               end else begin
                  word    = (in_data & keep) | mark;
                  state_d = pad_next;
               end
            end
         end
         S_MARK: begin
            if (load) begin
               emit    = 1'b1;
               word    = 32'h8000_0000;
               state_d = pad_next;
            end
         end
         S_ZERO: begin
            if (load) begin
               emit    = 1'b1;
               state_d = pad_next;
            end
         end
         S_LENH: begin
            if (load) begin
               emit    = 1'b1;
               word    = len[63:32];
               state_d = S_LENL;
            end
         end
         S_LENL: begin
            if (load) begin
               emit    = 1'b1;
               word    = len[31:0];
               word_me = 1'b1;
               cnt_d   = '0;
               state_d = S_DATA;
            end
         end
         default: state_d = S_DATA;
      endcase
   end

   always_comb begin
      ov_d   = ov_q;
      od_d   = od_q;
      be_d   = be_q;
      me_d   = me_q;
      wcnt_d = wcnt_q;
      if (load) begin
         ov_d = emit;
         if (emit) begin
            od_d   = word;
            be_d   = (wcnt_q == 4'd15);
            me_d   = word_me;
            wcnt_d = wcnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (reset) begin
         state_q <= S_DATA;
         wcnt_q  <= 4'd0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         ov_q    <= 1'b0;
         od_q    <= 32'h0;
         be_q    <= 1'b0;
         me_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         ov_q    <= ov_d;
         od_q    <= od_d;
         be_q    <= be_d;
         me_q    <= me_d;
      end
   end

   assign out_valid     = ov_q;
   assign out_data      = od_q;
   assign out_block_end = be_q;
   assign out_msg_end   = me_q;
   assign err           = err_q;
   assign busy          = (state_q != S_DATA) | (cnt_q != '0) | ov_q;
   assign dbg_state_o   = state_q;

endmodule
